zero_pattern_gen: RTL and testbench

ZERO_PATTERN_GEN -- requirements
Module: zero_pattern_gen

---
 rtl/zero_pattern_gen_if.sv | 38 +++
 rtl/zero_pattern_gen.sv | 109 ++++++++++
 tb/tb_zero_pattern_gen.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/zero_pattern_gen_if.sv
// Request/result handshake bundle for zero_pattern_gen.
// The master side issues requests and consumes results; the slave side is the generator.
interface zero_pattern_gen_if #(
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [CW-1:0]    count;
    logic             leading_or_trailing;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data;
    logic             err;

    modport master (
        output in_valid,
        output count,
        output leading_or_trailing,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  data,
        input  err
    );

    modport slave (
        input  in_valid,
        input  count,
        input  leading_or_trailing,
        input  out_ready,
        output in_ready,
        output out_valid,
        output data,
        output err
    );
endinterface

// File: rtl/zero_pattern_gen.sv
// Builds the canonical word with exactly `count` leading (or trailing) zeros
// followed by a single 1 by walking a one-hot seed across the word, one bit per cycle.
//
// state | meaning
// IDLE  | waiting for a request, in_ready = 1
// SHIFT | moving the seed bit one position per cycle until the counter empties
// DONE  | result valid, held until the consumer takes it
module zero_pattern_gen #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    zero_pattern_gen_if.slave    bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    WIDTH_C = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LSB_ONLY = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    cnt_q;
    logic             dir_q;
    logic             err_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] seed_d;
    logic [WIDTH-1:0] shift_d;

    // Seed for a new request and the one-step shift of the current word (zero fill).
    always_comb begin
        seed_d  = bus.leading_or_trailing ? MSB_ONLY : LSB_ONLY;
        shift_d = dir_q ? (data_q >> 1) : (data_q << 1);
    end

    // Control FSM; handshake outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        dir_q      <= bus.leading_or_trailing;
                        in_ready_q <= 1'b0;
                        if (bus.count > WIDTH_C) begin
                            // Out-of-range request: report immediately, no shifting.
                            data_q      <= '0;
                            cnt_q       <= '0;
                            err_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            data_q <= seed_d;
                            cnt_q  <= bus.count;
                            err_q  <= 1'b0;
                            if (bus.count == '0) begin
                                out_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end else begin
                                state_q <= SHIFT;
                            end
                        end
                    end
                end
                SHIFT: begin
                    data_q <= shift_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // Data is kept after the handshake; only the error flag clears.
                    if (bus.out_ready) begin
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.data      = data_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_zero_pattern_gen.sv
// Directed bench for zero_pattern_gen (WIDTH = 32).
module tb_zero_pattern_gen;
    localparam int WIDTH = 32;
    localparam int MAXW  = 200;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   lat;

    zero_pattern_gen_if #(.WIDTH(WIDTH)) bus ();

    zero_pattern_gen #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent zero counter used for the round-trip checks.
    function automatic int zcount(input logic [31:0] w, input logic lead);
        int z;
        z = 0;
        if (lead) begin
            for (int i = 31; i >= 0; i--) begin
                if (w[i]) break;
                z++;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (w[i]) break;
                z++;
            end
        end
        return z;
    endfunction

    // Issue one request at the next rising edge; latency = edges after acceptance until out_valid.
    task automatic do_req(input logic lead, input logic [5:0] cnt, output int latency);
        chk("accept_ready", bus.in_ready, 1);
        bus.in_valid            = 1'b1;
        bus.leading_or_trailing = lead;
        bus.count               = cnt;
        @(negedge clk);
        bus.in_valid = 1'b0;
        latency = 0;
        while (!bus.out_valid && latency < MAXW) begin
            @(negedge clk);
            latency++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid            = 1'b0;
        bus.count               = '0;
        bus.leading_or_trailing = 1'b0;
        bus.out_ready           = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_data", bus.data, 0);
        chk("rst_err", bus.err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Leading, count 0
        do_req(1'b1, 6'd0, lat);
        chk("l0_lat", lat, 0);
        chk("l0_data", bus.data, 32'h8000_0000);
        chk("l0_err", bus.err, 0);
        chk("l0_in_ready_busy", bus.in_ready, 0);
        consume();
        chk("l0_post_in_ready", bus.in_ready, 1);
        chk("l0_post_out_valid", bus.out_valid, 0);
        chk("l0_post_data_held", bus.data, 32'h8000_0000);

        // Trailing, count 9, held with out_ready low
        do_req(1'b0, 6'd9, lat);
        chk("t9_lat", lat, 9);
        chk("t9_data", bus.data, 32'h0000_0200);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t9_hold_data", bus.data, 32'h0000_0200);
            chk("t9_hold_valid", bus.out_valid, 1);
        end
        consume();

        // Leading, count 32 -> all zeros, no error
        do_req(1'b1, 6'd32, lat);
        chk("l32_lat", lat, 32);
        chk("l32_data", bus.data, 0);
        chk("l32_err", bus.err, 0);
        consume();

        // Count 40 -> error, direct to DONE
        do_req(1'b1, 6'd40, lat);
        chk("e40_lat", lat, 0);
        chk("e40_data", bus.data, 0);
        chk("e40_err", bus.err, 1);
        consume();
        chk("e40_err_cleared", bus.err, 0);

        // out_ready while not valid has no effect
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("or_idle_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.leading_or_trailing = 1'b0; bus.count = 6'd3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("or_shift_valid", bus.out_valid, 0);
        repeat (2) @(negedge clk);
        chk("or_done_valid", bus.out_valid, 1);
        chk("or_done_data", bus.data, 32'h0000_0008);
        consume();

        // in_valid held high with new values during SHIFT
        do_req(1'b0, 6'd4, lat);
        bus.in_valid = 1'b1; bus.leading_or_trailing = 1'b1; bus.count = 6'd7;
        chk("busy_lat", lat, 4);
        chk("busy_data", bus.data, 32'h0000_0010);
        chk("busy_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("busy_hs_in_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("busy_next_accepted", bus.in_ready, 0);
        lat = 0;
        while (!bus.out_valid && lat < MAXW) begin
            @(negedge clk);
            lat++;
        end
        chk("busy_next_lat", lat, 7);
        chk("busy_next_data", bus.data, 32'h0100_0000);
        consume();

        // Reset mid-SHIFT aborts immediately
        bus.in_valid = 1'b1; bus.leading_or_trailing = 1'b1; bus.count = 6'd20;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_data", bus.data, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_req(1'b1, 6'd6, lat);
        chk("after_abort_lat", lat, 6);
        chk("after_abort_data", bus.data, 32'h0200_0000);
        consume();

        // Round-trip sweep
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n <= 32; n++) begin
                do_req(d[0], 6'(n), lat);
                chk("sweep_lat", lat, n);
                chk("sweep_zcount", zcount(bus.data, d[0]), n);
                consume();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
